axis_video_pad: RTL and testbench

- Inverse of the crop stage: embeds a VIDEO_IN_W x VIDEO_IN_H AXI4-Stream video frame into a larger VIDEO_OUT_W x VIDEO_OUT_H canvas at (H_OFFSET, V_OFFSET).
- Positions outside the window are filled with PAD_VALUE.
- Sits after the crop/processing chain, ahead of the display/VDMA path, so downstream always sees the full output raster.
- Output is raster-generated: border beats are emitted without consuming input.

---
 rtl/axis_video_pkg.sv | 9 +
 rtl/axis_video_pos_counter.sv | 38 +++
 rtl/axis_video_pad.sv | 120 ++++++++++++
 tb/tb_axis_video_pad.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared counter width, state type and window helpers for the video pad/crop path
package axis_video_pkg;
  localparam int POS_W = 16;
  typedef enum logic {IDLE, FRAME} state_t;
  // First position past a window that starts at off and spans len positions
  function automatic logic [POS_W-1:0] win_end(input int off, input int len);
    return POS_W'(off + len);
  endfunction
endpackage

// File: rtl/axis_video_pos_counter.sv
// axis_video_pos_counter: h/v raster position with enable, sync clear, wrap and first/last flags
module axis_video_pos_counter
  import axis_video_pkg::*;
#(
  parameter int W = 1920,
  parameter int H = 1080
) (
  input  logic             axis_clk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             en,
  output logic [POS_W-1:0] h_cnt,
  output logic [POS_W-1:0] v_cnt,
  output logic             h_last,
  output logic             first,
  output logic             last
);
  localparam logic [POS_W-1:0] H_MAX = POS_W'(W - 1);
  localparam logic [POS_W-1:0] V_MAX = POS_W'(H - 1);
  logic v_last;
  assign h_last = h_cnt == H_MAX;
  assign v_last = v_cnt == V_MAX;
  assign first = h_cnt == '0 && v_cnt == '0;
  assign last = h_last && v_last;
  // step one position per enabled beat, wrapping at line and frame end
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      v_cnt <= h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
    end
  end
endmodule

// File: rtl/axis_video_pad.sv
// axis_video_pad: embeds an AXI4-Stream video frame into a larger canvas filled with a pad pixel
module axis_video_pad
  import axis_video_pkg::*;
#(
  parameter int VIDEO_IN_W = 640,
  parameter int VIDEO_IN_H = 480,
  parameter int VIDEO_OUT_W = 1920,
  parameter int VIDEO_OUT_H = 1080,
  parameter int H_OFFSET = 640,
  parameter int V_OFFSET = 300,
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  sof_err,
  output logic                  eol_err
);
  localparam logic [POS_W-1:0] H_LO = POS_W'(H_OFFSET);
  localparam logic [POS_W-1:0] V_LO = POS_W'(V_OFFSET);
  localparam logic [POS_W-1:0] WIN_H_END = win_end(H_OFFSET, VIDEO_IN_W);
  localparam logic [POS_W-1:0] WIN_V_END = win_end(V_OFFSET, VIDEO_IN_H);
  localparam logic [POS_W-1:0] H_WIN_LAST = WIN_H_END - 1'b1;
  state_t state, state_nx;
  logic abort, abort_nx;
  logic [POS_W-1:0] h_cnt, v_cnt;
  logic h_last, first, last;
  logic adv, in_win, win_first, win_data, early_sof, accept, produce, clr;
  logic [DATA_WIDTH-1:0] beat_data;

  axis_video_pos_counter #(.W(VIDEO_OUT_W), .H(VIDEO_OUT_H)) u_pos (
    .axis_clk(axis_clk),
    .aresetn (aresetn),
    .clr     (clr),
    .en      (produce),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .h_last  (h_last),
    .first   (first),
    .last    (last)
  );

  assign adv = !m_axis_tvalid || m_axis_tready;
  assign in_win = v_cnt >= V_LO && v_cnt < WIN_V_END && h_cnt >= H_LO && h_cnt < WIN_H_END;
  assign win_first = h_cnt == H_LO && v_cnt == V_LO;
  assign win_data = in_win && !abort;

  // frame sequencing: qualify SOF in IDLE, then emit pad or passed-through beats in raster order
  always_comb begin
    state_nx = state;
    abort_nx = abort;
    s_axis_tready = 1'b0;
    produce = 1'b0;
    accept = 1'b0;
    early_sof = 1'b0;
    clr = 1'b0;
    beat_data = PAD_VALUE;
    if (state == IDLE) begin
      s_axis_tready = s_axis_tvalid && !s_axis_tuser[0];
      clr = s_axis_tvalid && s_axis_tuser[0];
      state_nx = clr ? FRAME : IDLE;
    end else if (win_data) begin
      early_sof = !win_first && s_axis_tvalid && s_axis_tuser[0];
      s_axis_tready = adv && !early_sof;
      accept = s_axis_tvalid && s_axis_tready;
      produce = accept;
      beat_data = s_axis_tdata;
      abort_nx = early_sof;
    end else begin
      produce = adv;
    end
    if (produce && last) begin
      state_nx = IDLE;
      abort_nx = 1'b0;
    end
  end

  // state and abort flag registers
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      abort <= 1'b0;
    end else begin
      state <= state_nx;
      abort <= abort_nx;
    end
  end

  // output stage holds under backpressure; error flags are single-cycle pulses
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
      sof_err <= 1'b0;
      eol_err <= 1'b0;
    end else begin
      sof_err <= early_sof;
      eol_err <= accept && (s_axis_tlast != (h_cnt == H_WIN_LAST));
      if (adv) m_axis_tvalid <= produce;
      if (produce) begin
        m_axis_tdata <= beat_data;
        m_axis_tlast <= h_last;
        m_axis_tuser <= USER_WIDTH'(first);
      end
    end
  end
endmodule

// File: tb/tb_axis_video_pad.sv
// tb_axis_video_pad: scoreboard bench for the video pad stage on an 8x4 canvas with a 4x2 window
module tb_axis_video_pad;
  localparam int IW = 4, IH = 2, OW = 8, OH = 4, HO = 2, VO = 1, DW = 24, UW = 1;
  localparam logic [DW-1:0] PAD = 24'hFF0000;
  typedef struct packed {logic [DW-1:0] d; logic l; logic u;} beat_t;

  logic axis_clk = 0, aresetn = 0;
  logic [DW-1:0] s_tdata = '0;
  logic s_tvalid = 0, s_tready, s_tlast = 0;
  logic [UW-1:0] s_tuser = '0;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1, m_tlast;
  logic [UW-1:0] m_tuser;
  logic sof_err, eol_err;

  beat_t exp_q[$];
  beat_t held, got, want;
  bit stalled = 0, toggle_rdy = 0, gaps = 0, kill = 0;
  int vectors = 0, miscompares = 0, out_cnt = 0, sof_cnt = 0, eol_cnt = 0, sent = 0;

  axis_video_pad #(
    .VIDEO_IN_W(IW), .VIDEO_IN_H(IH), .VIDEO_OUT_W(OW), .VIDEO_OUT_H(OH),
    .H_OFFSET(HO), .V_OFFSET(VO), .DATA_WIDTH(DW), .USER_WIDTH(UW), .PAD_VALUE(PAD)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .sof_err(sof_err), .eol_err(eol_err)
  );

  always #5 axis_clk = ~axis_clk;

  initial forever begin
    @(posedge axis_clk);
    #1;
    m_tready = toggle_rdy ? ~m_tready : 1'b1;
  end

  always @(negedge axis_clk) begin
    if (aresetn) begin
      if (sof_err) sof_cnt++;
      if (eol_err) eol_cnt++;
      got = {m_tdata, m_tlast, m_tuser[0]};
      if (stalled) begin
        vectors++;
        if (!m_tvalid || got !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", m_tvalid, got, held);
        end
      end
      stalled = m_tvalid && !m_tready;
      held = got;
      if (m_tvalid && m_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat_%0d: got unexpected data=%h last=%b user=%b, required no beat", out_cnt, m_tdata, m_tlast, m_tuser[0]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL beat_%0d: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                     out_cnt, got.d, got.l, got.u, want.d, want.l, want.u);
          end
        end
        out_cnt++;
      end
    end else stalled = 0;
  end

  task automatic push_frame(input logic [DW-1:0] base, input int abort_idx);
    for (int b = 0; b < OW * OH; b++) begin
      int h = b % OW;
      int v = b / OW;
      beat_t e;
      e.d = PAD;
      if (v >= VO && v < VO + IH && h >= HO && h < HO + IW && (v - VO) * IW + (h - HO) < abort_idx)
        e.d = base + DW'((v - VO) * IW + (h - HO));
      e.l = h == OW - 1;
      e.u = b == 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
    int n = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_tvalid = 0;
      @(posedge axis_clk);
      #1;
    end
    s_tdata = d;
    s_tuser = u;
    s_tlast = l;
    s_tvalid = 1;
    @(negedge axis_clk);
    while (!s_tready && !kill && n < 500) begin
      @(negedge axis_clk);
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: beat %h not accepted in 500 cycles, required acceptance", d);
    end
    if (s_tready && !kill) sent++;
    @(posedge axis_clk);
    #1;
    s_tvalid = 0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input logic [7:0] lasts);
    for (int k = 0; k < IW * IH; k++) begin
      if (kill) break;
      send(base + DW'(k), k == 0, lasts[k]);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge axis_clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge axis_clk);
    #1;
    vectors++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata, sof_err, eol_err, s_tready} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b last=%b user=%b data=%h sof=%b eol=%b rdy=%b, required all 0",
               m_tvalid, m_tlast, m_tuser, m_tdata, sof_err, eol_err, s_tready);
    end
    aresetn = 1;
    repeat (2) @(posedge axis_clk);
    #1;
  endtask

  task automatic test_basic;
    out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
    push_frame(24'd1, 8);
    send_frame(24'd1, 8'b1000_1000);
    wait_drain("basic");
    vectors++;
    if (out_cnt != 32 || sof_cnt != 0 || eol_cnt != 0) begin
      miscompares++;
      $display("FAIL basic_counts: got beats=%0d sof=%0d eol=%0d, required 32 0 0", out_cnt, sof_cnt, eol_cnt);
    end
  endtask

  task automatic test_back_to_back;
    out_cnt = 0;
    toggle_rdy = 1;
    gaps = 1;
    push_frame(24'd1, 8);
    send_frame(24'd1, 8'b1000_1000);
    wait_drain("backpressure");
    toggle_rdy = 0;
    gaps = 0;
    vectors++;
    if (out_cnt != 32) begin
      miscompares++;
      $display("FAIL backpressure_count: got %0d beats, required 32", out_cnt);
    end
  endtask

  task automatic test_idle_drop;
    out_cnt = 0;
    sent = 0;
    for (int k = 0; k < 3; k++) send(24'hAA0000 + DW'(k), 1'b0, 1'b0);
    repeat (4) @(posedge axis_clk);
    #1;
    vectors++;
    if (sent != 3 || out_cnt != 0) begin
      miscompares++;
      $display("FAIL idle_drop: got consumed=%0d beats=%0d, required consumed=3 beats=0", sent, out_cnt);
    end
    push_frame(24'h20, 8);
    send_frame(24'h20, 8'b1000_1000);
    wait_drain("idle_drop");
    vectors++;
    if (out_cnt != 32) begin
      miscompares++;
      $display("FAIL idle_drop_count: got %0d beats, required 32", out_cnt);
    end
  endtask

  task automatic test_early_sof;
    out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
    push_frame(24'd1, 2);
    push_frame(24'h30, 8);
    send(24'd1, 1'b1, 1'b0);
    send(24'd2, 1'b0, 1'b0);
    send_frame(24'h30, 8'b1000_1000);
    wait_drain("early_sof");
    vectors++;
    if (sof_cnt != 1 || eol_cnt != 0 || out_cnt != 64) begin
      miscompares++;
      $display("FAIL early_sof_counts: got sof=%0d eol=%0d beats=%0d, required 1 0 64", sof_cnt, eol_cnt, out_cnt);
    end
  endtask

  task automatic test_eol;
    out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
    push_frame(24'h40, 8);
    send_frame(24'h40, 8'b1000_0010);
    wait_drain("eol");
    vectors++;
    if (eol_cnt != 2 || sof_cnt != 0) begin
      miscompares++;
      $display("FAIL eol_pulses: got eol=%0d sof=%0d, required 2 0", eol_cnt, sof_cnt);
    end
  endtask

  task automatic test_reset_mid;
    out_cnt = 0;
    push_frame(24'd1, 8);
    fork
      send_frame(24'd1, 8'b1000_1000);
      begin
        int n = 0;
        while (out_cnt < 15 && n < 1000) begin
          @(posedge axis_clk);
          n++;
        end
        @(posedge axis_clk);
        #2;
        aresetn = 0;
        kill = 1;
        #1;
        vectors++;
        if (out_cnt < 15 || m_tvalid !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_mid: got beats=%0d valid=%b, required beats>=15 valid=0", out_cnt, m_tvalid);
        end
      end
    join
    exp_q.delete();
    repeat (2) @(posedge axis_clk);
    #1;
    kill = 0;
    aresetn = 1;
    out_cnt = 0;
    repeat (2) @(posedge axis_clk);
    #1;
    push_frame(24'h50, 8);
    send_frame(24'h50, 8'b1000_1000);
    wait_drain("after_reset");
    vectors++;
    if (out_cnt != 32) begin
      miscompares++;
      $display("FAIL after_reset_count: got %0d beats, required 32", out_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_idle_drop;
    test_early_sof;
    test_eol;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
